// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the 32x64 register file.
// Imported by regfile, decoder5_32 and regfile_reg64.
package regfile_pkg;

    localparam int WIDTH  = 64;
    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;

    // XZR: reads as zero, writes are dropped.
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [WIDTH-1:0]  reg_data_t;

endpackage

// File: rtl/regfile_decoder5_32.sv
// decoder5_32: 5-bit address to 32-bit one-hot enable, gated by en_i.
// Ports: addr_i (address), en_i (enable), onehot_o (one-hot, all 0 if !en_i).
module decoder5_32
    import regfile_pkg::*;
(
    input  logic [4:0]  addr_i,
    input  logic        en_i,
    output logic [31:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < 32; i++) begin
            if (en_i && (addr_i == 5'(i))) begin
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_reg64.sv
// regfile_reg64: enable-gated register cell with synchronous active-high reset.
// Ports: clk, reset, en_i (load enable), d_i (load data), q_o (stored value).
module regfile_reg64
    import regfile_pkg::*;
#(
    parameter int W = regfile_pkg::WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (en_i) begin
            data_d = d_i;
        end
    end

    // Reset wins over a load in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/regfile.sv
// regfile: 32-entry x 64-bit register file, 1 write port, 2 combinational
// read ports; entry 31 (XZR) reads 0 and ignores writes.
// Ports: clk, reset (sync, active-high), ReadRegister1/2 -> ReadData1/2,
// WriteRegister/WriteData/RegWrite (write port, stored at posedge).
// Build option: define REGFILE_BYPASS_EN for same-cycle write-through.
module regfile #(
    parameter int WIDTH  = regfile_pkg::WIDTH,
    parameter int NREGS  = regfile_pkg::NREGS,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [WIDTH-1:0]  WriteData,
    input  logic              RegWrite,
    output logic [WIDTH-1:0]  ReadData1,
    output logic [WIDTH-1:0]  ReadData2
);

    import regfile_pkg::*;

    localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

    logic [31:0]      wr_en;
    logic [WIDTH-1:0] entry_q [NREGS-1];
    logic [WIDTH-1:0] mux1;
    logic [WIDTH-1:0] mux2;
    logic             unused_xzr_en;

    decoder5_32 u_dec (
        .addr_i   (5'(WriteRegister)),
        .en_i     (RegWrite),
        .onehot_o (wr_en)
    );

    // XZR has no storage, so its enable goes nowhere.
    assign unused_xzr_en = wr_en[NREGS-1];

    for (genvar g = 0; g < NREGS - 1; g++) begin : g_entry
        regfile_reg64 #(
            .W (WIDTH)
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .en_i  (wr_en[g]),
            .d_i   (WriteData),
            .q_o   (entry_q[g])
        );
    end

    // Read muxes: any address without storage (only 31) yields 0.
    always_comb begin
        mux1 = '0;
        mux2 = '0;
        for (int i = 0; i < NREGS - 1; i++) begin
            if (ReadRegister1 == ADDR_W'(i)) begin
                mux1 = entry_q[i];
            end
            if (ReadRegister2 == ADDR_W'(i)) begin
                mux2 = entry_q[i];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic wr_live;
    logic hit1;
    logic hit2;

    // A write lost to reset or aimed at XZR must not be forwarded.
    assign wr_live = RegWrite && !reset && (WriteRegister != ZR);
    assign hit1    = wr_live && (WriteRegister == ReadRegister1);
    assign hit2    = wr_live && (WriteRegister == ReadRegister2);

    assign ReadData1 = hit1 ? WriteData : mux1;
    assign ReadData2 = hit2 ? WriteData : mux2;
`else
    assign ReadData1 = mux1;
    assign ReadData2 = mux2;
`endif

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: randomized scoreboard bench for regfile.
// Driver pushes expected reads; a negedge monitor pops and compares.
module tb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic        RegWrite;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;

    regfile dut (
        .clk           (clk),
        .reset         (reset),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .RegWrite      (RegWrite),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [63:0] e1;
        logic [63:0] e2;
    } exp_t;

    exp_t        sbq[$];
    logic [63:0] mem [32];
    int          checks = 0;
    int          failures = 0;
    int          cycle = 0;
    bit          done = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    function automatic logic [63:0] model_rd(input logic [4:0] a,
                                             input bit r, input bit w,
                                             input logic [4:0] wa,
                                             input logic [63:0] wd);
        if (a == 5'd31) return 64'h0;
        if (BYPASS && w && !r && wa == a) return wd;
        return mem[a];
    endfunction

    // One clock of stimulus; chk=0 only before the first reset edge.
    task automatic step(input bit r, input bit w, input logic [4:0] wa,
                        input logic [63:0] wd, input logic [4:0] a1,
                        input logic [4:0] a2, input bit chk = 1'b1);
        exp_t e;
        @(posedge clk);
        #1;
        reset         = r;
        RegWrite      = w;
        WriteRegister = wa;
        WriteData     = wd;
        ReadRegister1 = a1;
        ReadRegister2 = a2;
        cycle++;
        if (chk) begin
            e.cyc = cycle;
            e.a1  = a1;
            e.a2  = a2;
            e.e1  = model_rd(a1, r, w, wa, wd);
            e.e2  = model_rd(a2, r, w, wa, wd);
            sbq.push_back(e);
        end
        if (r) begin
            for (int i = 0; i < 32; i++) mem[i] = 64'h0;
        end else if (w && wa != 5'd31) begin
            mem[wa] = wd;
        end
    endtask

    task automatic sweep();
        for (int a = 0; a < 32; a++) begin
            step(0, 0, 5'(a), 64'h0, 5'(a), 5'(31 - a));
        end
    endtask

    // Monitor: reads are combinational, so they are valid every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (ReadData1 !== e.e1) begin
                failures++;
                $display("FAIL rd1 cyc=%0d addr=%0d got=%h exp=%h",
                         e.cyc, e.a1, ReadData1, e.e1);
            end
            checks++;
            if (ReadData2 !== e.e2) begin
                failures++;
                $display("FAIL rd2 cyc=%0d addr=%0d got=%h exp=%h",
                         e.cyc, e.a2, ReadData2, e.e2);
            end
        end
    end

    initial begin
        reset = 1'b1;
        RegWrite = 1'b0;
        WriteRegister = '0;
        WriteData = '0;
        ReadRegister1 = '0;
        ReadRegister2 = '0;
        for (int i = 0; i < 32; i++) mem[i] = 64'h0;

        // Reset, then all addresses read 0 on both ports.
        step(1, 0, 0, 0, 0, 0, 1'b0);
        sweep();

        // Write X5, read X5 / X6 next cycle.
        step(0, 1, 5, 64'hDEADBEEF_CAFEF00D, 0, 1);
        step(0, 0, 0, 0, 5, 6);

        // Write to XZR: same cycle and after, reads 0; rest unchanged.
        step(0, 1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 31, 31);
        step(0, 0, 0, 0, 31, 31);
        sweep();

        // Same-cycle read/write of X7.
        step(0, 1, 7, 64'h77, 0, 0);
        step(0, 1, 7, 64'h1234, 7, 7);
        step(0, 0, 0, 0, 7, 7);

        // Load X0..X30, then reset while writing X3.
        for (int i = 0; i < 31; i++) begin
            step(0, 1, 5'(i), 64'(i * 32'h0101), 5'(i), 5'(30 - i));
        end
        step(1, 1, 3, 64'h55, 3, 4);
        sweep();

        // RegWrite=0 must not disturb X9.
        step(0, 1, 9, 64'h99, 0, 0);
        step(0, 0, 9, 64'hABCD, 9, 9);
        step(0, 0, 0, 0, 9, 9);

        // Random traffic with occasional resets and forced read/write hits.
        for (int n = 0; n < 3000; n++) begin
            logic [4:0]  wa;
            logic [4:0]  a1;
            logic [4:0]  a2;
            logic [63:0] wd;
            bit          r;
            bit          w;
            wa = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            wd = {$urandom, $urandom};
            r  = ($urandom_range(0, 59) == 0);
            w  = ($urandom_range(0, 2) != 0);
            step(r, w, wa, wd, a1, a2);
        end
        step(0, 0, 0, 0, 0, 0);
        sweep();

        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clk);
        @(posedge clk);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d exp=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
